ram2_responder: RTL
===================

RAM2_RESPONDER -- requirements
Module: ram2_responder

Interface
REQ-001 Parameter ADDR_W, default 8, number of low ram_addr bits decoded; depth 2^ADDR_W 16-bit words.
REQ-002 Parameter WAIT, default 1, read wait-state cycles (0..7).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 ram_addr  in  16  word address from initiator; bits above ADDR_W ignored.
REQ-006 ram_data_i  in  16  write data from initiator.
REQ-007 ram_ce  in  1  chip enable, active-low.
REQ-008 ram_re  in  1  read/output enable, active-low.
REQ-009 ram_we  in  1  write enable, active-low.
REQ-010 ram_data_o  out  16  read data.
REQ-011 ram_data_oe  out  1  high while ram_data_o drives valid read data.
REQ-012 ram_ready  out  1  one-cycle pulse on write commit; level while read data valid.
REQ-013 state_o  out  2  current state: 0 IDLE, 1 READ, 2 WRITE, 3 ERROR.
REQ-014 err  out  1  sticky protocol-error flag.
REQ-015 wr_cnt  out  8  committed-write count, saturating.
REQ-016 rd_cnt  out  8  completed-read count, saturating.

Function
REQ-017 IDLE: ram_ce=1 -> stay; ce=0,we=0,re=0 -> ERROR; ce=0,we=0 -> WRITE, latch addr/data; ce=0,re=0 -> READ, latch addr, load wait counter with WAIT.
REQ-018 WRITE: while ce=0,we=0, re-latch addr and data every cycle (last value wins).
REQ-019 WRITE: on first cycle with we=1 or ce=1, commit latched data to latched addr, pulse ram_ready one cycle, wr_cnt+1, go IDLE.
REQ-020 WRITE with re=0 while we=0 -> ERROR without commit.
REQ-021 READ: wait counter decrements each cycle; at 0, ram_data_o = mem[latched addr], ram_data_oe=1, ram_ready=1 held until exit.
REQ-022 WAIT=0: data valid on the cycle after entering READ.
REQ-023 READ: ram_addr change while ce=0,re=0 reloads counter, drops ram_data_oe/ram_ready until new data valid.
REQ-024 READ: re=1 or ce=1 -> IDLE next cycle, ram_data_oe=0, ram_ready=0; rd_cnt+1 only if data had been valid.
REQ-025 READ with we=0 -> ERROR, rd_cnt unchanged.
REQ-026 ERROR: err=1; memory never modified; stay until ram_ce=1, then IDLE; err stays 1 until reset.
REQ-027 wr_cnt and rd_cnt saturate at 255, never wrap.
REQ-028 ram_data_o = 0 whenever ram_data_oe=0.
REQ-029 Read of a location written in the same transaction sequence returns the committed value; no write-through/bypass of uncommitted data.

Reset
REQ-030 rst=0: state IDLE, state_o=0, ram_data_o=0, ram_data_oe=0, ram_ready=0, err=0, wr_cnt=0, rd_cnt=0, wait counter 0.
REQ-031 Memory contents not reset; unspecified until written.
REQ-032 Reset asserted mid-WRITE aborts without commit; mid-READ drops ram_data_oe immediately.

Verification
REQ-033 WAIT=1: write ce=0,we=0,addr=3,data=3 for 2 cycles, then we=1 -> commit pulse, wr_cnt=1, state_o 2->0.
REQ-034 Then ce=0,re=0,addr=3 -> ram_data_oe=1, ram_data_o=3 two cycles after entry; re=1 -> IDLE, rd_cnt=1.
REQ-035 Write addr=4 data=0xAAAA then addr changes to 5 data=0x5555 before we=1 -> only mem[5]=0x5555 committed; read addr 4 returns prior content.
REQ-036 ce=0,we=0,re=0 from IDLE -> state_o=3, err=1; ce=1 -> state_o=0, err stays 1; no counter change.
REQ-037 260 write transactions -> wr_cnt=255; rst=0 mid-WRITE -> all outputs 0, target word unchanged.

Source files
------------

// File: rtl/ram2_responder.sv
// Memory-mapped 16-bit SRAM-style responder: active-low strobes, programmable read
// wait states, sticky protocol-error detection and saturating transaction counters.
module ram2_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ram_addr,
  input  logic [15:0] ram_data_i,
  input  logic        ram_ce,
  input  logic        ram_re,
  input  logic        ram_we,
  output logic [15:0] ram_data_o,
  output logic        ram_data_oe,
  output logic        ram_ready,
  output logic [1:0]  state_o,
  output logic        err,
  output logic [7:0]  wr_cnt,
  output logic [7:0]  rd_cnt
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [2:0]  WAIT_LD = 3'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [15:0]         data_r;
  logic [2:0]          wait_r;
  logic [15:0]         mem_r [0:DEPTH-1];
  logic [ADDR_W-1:0]   addr_s;
  logic                commit_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    if (val == 8'd255) begin
      return 8'd255;
    end else begin
      return val + 8'd1;
    end
  endfunction

  assign addr_s  = ram_addr[ADDR_W-1:0];
  assign state_o = state_r;

  // Upper address bits are deliberately not decoded.
  generate
    if (ADDR_W < 16) begin : g_unused_addr
      logic unused_addr_s;
      assign unused_addr_s = ^ram_addr[15:ADDR_W];
    end
  endgenerate

  // Write commit happens on the first WRITE cycle where the initiator releases we or ce.
  always_comb begin
    commit_s = 1'b0;
    if ((state_r == ST_WRITE) && (ram_ce || ram_we)) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Storage array; not reset, and a commit is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (commit_s && rst) begin
      mem_r[addr_r] <= data_r;
    end
  end

  // Protocol FSM with registered outputs and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      data_r      <= 16'd0;
      wait_r      <= 3'd0;
      ram_data_o  <= 16'd0;
      ram_data_oe <= 1'b0;
      ram_ready   <= 1'b0;
      err         <= 1'b0;
      wr_cnt      <= 8'd0;
      rd_cnt      <= 8'd0;
    end else begin
      ram_ready <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ram_data_o  <= 16'd0;
          ram_data_oe <= 1'b0;
          if (!ram_ce) begin
            if (!ram_we && !ram_re) begin
              state_r <= ST_ERROR;
              err     <= 1'b1;
            end else if (!ram_we) begin
              state_r <= ST_WRITE;
              addr_r  <= addr_s;
              data_r  <= ram_data_i;
            end else if (!ram_re) begin
              state_r <= ST_READ;
              addr_r  <= addr_s;
              wait_r  <= WAIT_LD;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_WRITE: begin
          ram_data_o  <= 16'd0;
          ram_data_oe <= 1'b0;
          if (!ram_ce && !ram_we) begin
            if (!ram_re) begin
              state_r <= ST_ERROR;
              err     <= 1'b1;
            end else begin
              addr_r <= addr_s;
              data_r <= ram_data_i;
            end
          end else begin
            ram_ready <= 1'b1;
            wr_cnt    <= sat_inc(wr_cnt);
            state_r   <= ST_IDLE;
          end
        end

        ST_READ: begin
          if (ram_ce || ram_re) begin
            state_r     <= ST_IDLE;
            ram_data_o  <= 16'd0;
            ram_data_oe <= 1'b0;
            if (ram_data_oe) begin
              rd_cnt <= sat_inc(rd_cnt);
            end
          end else if (!ram_we) begin
            state_r     <= ST_ERROR;
            err         <= 1'b1;
            ram_data_o  <= 16'd0;
            ram_data_oe <= 1'b0;
          end else if (addr_s != addr_r) begin
            // A new address restarts the wait sequence and withdraws stale data.
            addr_r      <= addr_s;
            wait_r      <= WAIT_LD;
            ram_data_o  <= 16'd0;
            ram_data_oe <= 1'b0;
          end else if (wait_r == 3'd0) begin
            ram_data_o  <= mem_r[addr_r];
            ram_data_oe <= 1'b1;
            ram_ready   <= 1'b1;
          end else begin
            wait_r <= wait_r - 3'd1;
          end
        end

        ST_ERROR: begin
          err         <= 1'b1;
          ram_data_o  <= 16'd0;
          ram_data_oe <= 1'b0;
          if (ram_ce) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ERROR;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          ram_data_o  <= 16'd0;
          ram_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
